// File: rtl/status_register_unit_pkg.sv
// Shared definitions for the status register unit: NZCV bit positions in the
// packed register layout and the shadow save/restore FSM encoding.
package status_register_unit_pkg;

    localparam int STATUS_LEN   = 4;
    localparam int STATUS_Z_BIT = 3;
    localparam int STATUS_C_BIT = 2;
    localparam int STATUS_N_BIT = 1;
    localparam int STATUS_V_BIT = 0;

    typedef logic [STATUS_LEN-1:0] status_t;

    typedef enum logic {
        SHADOW_NORMAL = 1'b0,
        SHADOW_SAVED  = 1'b1
    } shadow_state_t;

endpackage

// File: rtl/status_register_unit_flag_gen.sv
// Combinational NZCV generation from execute-stage ALU outputs, packed {Z,C,N,V}.
// Zero latency; no flow control.
module status_register_unit_flag_gen
    import status_register_unit_pkg::*;
#(
    parameter int WORD_LEN = 32
) (
    input  logic [WORD_LEN-1:0] alu_result,
    input  logic                alu_carry,
    input  logic                alu_overflow,
    input  logic                logical_op,
    input  logic                cur_v,
    output status_t             flags
);

    always_comb begin
        flags               = '0;
        flags[STATUS_Z_BIT] = (alu_result == '0);
        flags[STATUS_C_BIT] = alu_carry;
        flags[STATUS_N_BIT] = alu_result[WORD_LEN-1];
        // Logical/move instructions leave V untouched.
        flags[STATUS_V_BIT] = logical_op ? cur_v : alu_overflow;
    end

endmodule

// File: rtl/status_register_unit.sv
// Architectural NZCV register with stall/flush gating and a one-deep shadow slot.
// Flags land one edge after the update cycle (status_next forwards them same-cycle); no backpressure.
module status_register_unit
    import status_register_unit_pkg::*;
#(
    parameter int WORD_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exe_valid,
    input  logic                  exe_stall,
    input  logic                  exe_flush,
    input  logic                  cond_pass,
    input  logic                  s_bit,
    input  logic                  logical_op,
    input  logic [WORD_LEN-1:0]   alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    input  logic                  save_req,
    input  logic                  restore_req,
    output logic [STATUS_LEN-1:0] status_register,
    output logic [STATUS_LEN-1:0] status_next,
    output logic                  shadow_valid,
    output logic                  seq_error
);

    shadow_state_t state, state_nxt;
    status_t       shadow, shadow_nxt;
    status_t       flags;
    status_t       upd_val;
    logic          upd;
    logic          err_nxt;

    status_register_unit_flag_gen #(
        .WORD_LEN (WORD_LEN)
    ) u_flag_gen (
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .logical_op   (logical_op),
        .cur_v        (status_register[STATUS_V_BIT]),
        .flags        (flags)
    );

    assign upd     = exe_valid & ~exe_stall & ~exe_flush & cond_pass & s_bit;
    assign upd_val = upd ? flags : status_register;

    // Restore outranks the update; a save captures the post-update value.
    always_comb begin
        state_nxt   = state;
        shadow_nxt  = shadow;
        status_next = upd_val;
        err_nxt     = 1'b0;
        if (save_req && restore_req) begin
            err_nxt = 1'b1;
        end else if (restore_req) begin
            if (state == SHADOW_SAVED) begin
                status_next = shadow;
                state_nxt   = SHADOW_NORMAL;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (save_req) begin
            if (state == SHADOW_NORMAL) begin
                shadow_nxt = upd_val;
                state_nxt  = SHADOW_SAVED;
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= SHADOW_NORMAL;
            shadow          <= '0;
            status_register <= '0;
            seq_error       <= 1'b0;
        end else begin
            state           <= state_nxt;
            shadow          <= shadow_nxt;
            status_register <= status_next;
            seq_error       <= err_nxt;
        end
    end

    assign shadow_valid = (state == SHADOW_SAVED);

endmodule

// File: tb/tb_status_register_unit.sv
// Directed-vector bench for status_register_unit; flags are packed {Z,C,N,V}.
module tb_status_register_unit;

    localparam int WORD_LEN = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                exe_valid, exe_stall, exe_flush, cond_pass, s_bit, logical_op;
    logic [WORD_LEN-1:0] alu_result;
    logic                alu_carry, alu_overflow, save_req, restore_req;
    logic [3:0]          status_register, status_next;
    logic                shadow_valid, seq_error;

    int assertions = 0;
    int failures   = 0;

    status_register_unit #(.WORD_LEN(WORD_LEN)) dut (
        .clk             (clk),
        .rst             (rst),
        .exe_valid       (exe_valid),
        .exe_stall       (exe_stall),
        .exe_flush       (exe_flush),
        .cond_pass       (cond_pass),
        .s_bit           (s_bit),
        .logical_op      (logical_op),
        .alu_result      (alu_result),
        .alu_carry       (alu_carry),
        .alu_overflow    (alu_overflow),
        .save_req        (save_req),
        .restore_req     (restore_req),
        .status_register (status_register),
        .status_next     (status_next),
        .shadow_valid    (shadow_valid),
        .seq_error       (seq_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exe_valid = 0; exe_stall = 0; exe_flush = 0; cond_pass = 0; s_bit = 0;
        logical_op = 0; alu_result = '0; alu_carry = 0; alu_overflow = 0;
        save_req = 0; restore_req = 0;
    endtask

    task automatic op(input logic logical, input logic [WORD_LEN-1:0] res,
                      input logic c, input logic v);
        exe_valid = 1; cond_pass = 1; s_bit = 1; exe_stall = 0; exe_flush = 0;
        logical_op = logical; alu_result = res; alu_carry = c; alu_overflow = v;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick(); tick();
        assertions++;
        if (status_register !== 4'b0000) begin failures++; $display("FAIL reset_status got %b want 0000", status_register); end
        assertions++;
        if (status_next !== 4'b0000) begin failures++; $display("FAIL reset_next got %b want 0000", status_next); end
        assertions++;
        if (shadow_valid !== 1'b0 || seq_error !== 1'b0) begin
            failures++; $display("FAIL reset_shadow_err got %b%b want 00", shadow_valid, seq_error);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_adds();
        op(0, 32'h0, 1, 0);
        #1;
        assertions++;
        if (status_next !== 4'b1100) begin failures++; $display("FAIL adds_next got %b want 1100", status_next); end
        tick(); idle(); #1;
        assertions++;
        if (status_register !== 4'b1100) begin failures++; $display("FAIL adds_reg got %b want 1100", status_register); end
    endtask

    task automatic test_cond();
        op(0, 32'h8000_0000, 0, 1);
        cond_pass = 0;
        tick();
        assertions++;
        if (status_register !== 4'b1100) begin failures++; $display("FAIL cond_fail_reg got %b want 1100", status_register); end
        cond_pass = 1;
        tick(); idle(); #1;
        assertions++;
        if (status_register !== 4'b0011) begin failures++; $display("FAIL cond_pass_reg got %b want 0011", status_register); end
    endtask

    task automatic test_movs();
        op(0, 32'h1, 0, 1);
        tick();
        assertions++;
        if (status_register !== 4'b0001) begin failures++; $display("FAIL movs_setup got %b want 0001", status_register); end
        op(1, 32'hFFFF_FFFF, 0, 0);
        #1;
        assertions++;
        if (status_next !== 4'b0011) begin failures++; $display("FAIL movs_next got %b want 0011", status_next); end
        tick(); idle(); #1;
        assertions++;
        if (status_register !== 4'b0011) begin failures++; $display("FAIL movs_reg got %b want 0011", status_register); end
    endtask

    task automatic test_stall();
        op(0, 32'h0, 1, 0);
        exe_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            assertions++;
            if (status_next !== 4'b0011) begin failures++; $display("FAIL stall_next[%0d] got %b want 0011", i, status_next); end
            tick();
            assertions++;
            if (status_register !== 4'b0011) begin failures++; $display("FAIL stall_reg[%0d] got %b want 0011", i, status_register); end
        end
        exe_stall = 0;
        #1;
        assertions++;
        if (status_next !== 4'b1100) begin failures++; $display("FAIL unstall_next got %b want 1100", status_next); end
        tick(); idle(); #1;
        assertions++;
        if (status_register !== 4'b1100) begin failures++; $display("FAIL unstall_reg got %b want 1100", status_register); end
    endtask

    task automatic test_flush();
        op(0, 32'h8000_0000, 0, 1);
        exe_flush = 1;
        #1;
        assertions++;
        if (status_next !== 4'b1100) begin failures++; $display("FAIL flush_next got %b want 1100", status_next); end
        tick(); idle(); #1;
        assertions++;
        if (status_register !== 4'b1100) begin failures++; $display("FAIL flush_reg got %b want 1100", status_register); end
    endtask

    task automatic test_shadow();
        // Save in the same cycle as an update to 1000: the shadow must take 1000.
        op(0, 32'h0, 0, 0);
        save_req = 1;
        tick(); idle();
        assertions++;
        if (status_register !== 4'b1000 || shadow_valid !== 1'b1) begin
            failures++; $display("FAIL save_state got reg=%b sv=%b want reg=1000 sv=1", status_register, shadow_valid);
        end
        op(0, 32'h1, 1, 0); tick();
        op(0, 32'h1, 1, 0); tick();
        assertions++;
        if (status_register !== 4'b0100) begin failures++; $display("FAIL post_save_upd got %b want 0100", status_register); end
        op(0, 32'h8000_0000, 1, 1);
        restore_req = 1;
        #1;
        assertions++;
        if (status_next !== 4'b1000) begin failures++; $display("FAIL restore_next got %b want 1000", status_next); end
        tick(); idle(); #1;
        assertions++;
        if (status_register !== 4'b1000 || shadow_valid !== 1'b0 || seq_error !== 1'b0) begin
            failures++; $display("FAIL restore got reg=%b sv=%b err=%b want 1000/0/0", status_register, shadow_valid, seq_error);
        end
        // Restore while NORMAL: flagged, but the accompanying update still lands.
        op(0, 32'h0, 1, 0);
        restore_req = 1;
        tick(); idle(); #1;
        assertions++;
        if (seq_error !== 1'b1 || status_register !== 4'b1100) begin
            failures++; $display("FAIL bad_restore got err=%b reg=%b want 1/1100", seq_error, status_register);
        end
        tick();
        assertions++;
        if (seq_error !== 1'b0) begin failures++; $display("FAIL err_pulse_width got %b want 0", seq_error); end
        save_req = 1;
        tick();
        save_req = 1;
        tick(); idle(); #1;
        assertions++;
        if (seq_error !== 1'b1 || shadow_valid !== 1'b1) begin
            failures++; $display("FAIL double_save got err=%b sv=%b want 1/1", seq_error, shadow_valid);
        end
        save_req = 1; restore_req = 1;
        tick(); idle(); #1;
        assertions++;
        if (seq_error !== 1'b1 || shadow_valid !== 1'b1) begin
            failures++; $display("FAIL save_and_restore got err=%b sv=%b want 1/1", seq_error, shadow_valid);
        end
        op(0, 32'h1, 0, 0);
        restore_req = 1;
        tick(); idle(); #1;
        assertions++;
        if (status_register !== 4'b1100 || shadow_valid !== 1'b0 || seq_error !== 1'b0) begin
            failures++; $display("FAIL shadow_kept got reg=%b sv=%b err=%b want 1100/0/0", status_register, shadow_valid, seq_error);
        end
    endtask

    task automatic test_async_reset();
        // Z and N cannot both be set, so 1101 is the fullest reachable pattern.
        op(0, 32'h0, 1, 1);
        save_req = 1;
        tick(); idle();
        assertions++;
        if (status_register !== 4'b1101 || shadow_valid !== 1'b1) begin
            failures++; $display("FAIL pre_rst got reg=%b sv=%b want 1101/1", status_register, shadow_valid);
        end
        #2;
        rst = 1;
        #1;
        assertions++;
        if (status_register !== 4'b0000 || shadow_valid !== 1'b0 || seq_error !== 1'b0) begin
            failures++; $display("FAIL async_rst got reg=%b sv=%b err=%b want 0000/0/0", status_register, shadow_valid, seq_error);
        end
        tick();
        rst = 0;
        restore_req = 1;
        tick(); idle(); #1;
        assertions++;
        if (seq_error !== 1'b1 || status_register !== 4'b0000) begin
            failures++; $display("FAIL post_rst_restore got err=%b reg=%b want 1/0000", seq_error, status_register);
        end
    endtask

    initial begin
        test_reset();
        test_adds();
        test_cond();
        test_movs();
        test_stall();
        test_flush();
        test_shadow();
        test_async_reset();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
